// File: rtl/tt_pkg.sv
// Shared constants for the truth-table checker: state encoding and the
// expected truth tables of the exercise functions (bit i = output for vector i).
package tt_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_REPORT  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_COLLECT = ST_COLLECT,
        S_REPORT  = ST_REPORT
    } tt_state_e;

    localparam logic [3:0] TT_NOR2       = 4'b0001;
    localparam logic [3:0] TT_NOTA_AND_B = 4'b0100;
    localparam logic [3:0] TT_AND2       = 4'b1000;
    localparam logic [3:0] TT_XOR2       = 4'b0110;

endpackage

// File: rtl/sat_counter.sv
// CW-bit up counter with enable and synchronous clear; sticks at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/truth_table_checker.sv
// Compares observed (vector, output) samples against an expected truth table,
// counts mismatches and coverage, and reports pass/fail once every row is seen.
module truth_table_checker
    import tt_pkg::*;
#(
    parameter int                  N_IN   = 2,
    parameter logic [2**N_IN-1:0]  EXPECT = TT_NOR2,
    parameter int                  CW     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_vec,
    input  logic              in_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CW-1:0]     err_count,
    output logic [CW-1:0]     sample_count,
    output logic [2**N_IN-1:0] seen,
    output logic              first_err_valid,
    output logic [N_IN-1:0]   first_err_vec,
    output logic [1:0]        state_dbg
);

    localparam int ROWS = 2**N_IN;

    // Handshake: a sample transfers on every rising clk edge where
    // in_valid & in_ready; in_ready depends only on the registered state.

    tt_state_e       state, next_state;
    logic            accept, clear, mismatch, complete;
    logic [ROWS-1:0] expect_tbl;
    logic [ROWS-1:0] vec_bit;
    logic [ROWS-1:0] seen_next;

    assign expect_tbl = EXPECT;
    assign vec_bit    = ROWS'(1) << in_vec;
    assign in_ready   = (state == S_COLLECT);
    assign busy       = (state == S_COLLECT);
    assign state_dbg  = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        clear      = 1'b0;
        mismatch   = 1'b0;
        seen_next  = seen;
        complete   = 1'b0;
        case (state)
            S_IDLE, S_REPORT: begin
                if (start) begin
                    clear      = 1'b1;
                    next_state = S_COLLECT;
                end
            end
            S_COLLECT: begin
                accept = in_valid;
                if (accept) begin
                    // Unknown observed outputs must count as errors.
                    mismatch  = (in_out !== expect_tbl[in_vec]);
                    seen_next = seen | vec_bit;
                    complete  = &seen_next;
                end
                if (complete) begin
                    next_state = S_REPORT;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    sat_counter #(.CW(CW)) u_err_cnt (
        .clk   (clk),
        .rst   (reset),
        .clr   (clear),
        .en    (mismatch),
        .count (err_count)
    );

    sat_counter #(.CW(CW)) u_sample_cnt (
        .clk   (clk),
        .rst   (reset),
        .clr   (clear),
        .en    (accept),
        .count (sample_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen            <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
        end else begin
            done <= complete;
            if (clear) begin
                seen            <= '0;
                first_err_valid <= 1'b0;
                first_err_vec   <= '0;
                pass            <= 1'b0;
            end else begin
                seen <= seen_next;
                if (mismatch && !first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_vec   <= in_vec;
                end
                // err_count has not yet absorbed this edge's mismatch.
                if (complete) begin
                    pass <= (err_count == '0) && !mismatch;
                end
            end
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: a default-width instance (NOR2, CW=8)
// and a CW=2 instance share all inputs so saturation can be compared side by side.
module tb_truth_table_checker;

    logic       clk;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [1:0] in_vec;
    logic       in_out;

    logic       in_ready, busy, done, pass, first_err_valid;
    logic [7:0] err_count, sample_count;
    logic [3:0] seen;
    logic [1:0] first_err_vec, state_dbg;

    logic       in_ready_s, busy_s, done_s, pass_s, first_err_valid_s;
    logic [1:0] err_count_s, sample_count_s;
    logic [3:0] seen_s;
    logic [1:0] first_err_vec_s, state_dbg_s;

    int checks;
    int failures;
    logic [7:0] exp_q[$];

    truth_table_checker dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_vec          (in_vec),
        .in_out          (in_out),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .sample_count    (sample_count),
        .seen            (seen),
        .first_err_valid (first_err_valid),
        .first_err_vec   (first_err_vec),
        .state_dbg       (state_dbg)
    );

    truth_table_checker #(.CW(2)) dut_s (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .in_valid        (in_valid),
        .in_ready        (in_ready_s),
        .in_vec          (in_vec),
        .in_out          (in_out),
        .busy            (busy_s),
        .done            (done_s),
        .pass            (pass_s),
        .err_count       (err_count_s),
        .sample_count    (sample_count_s),
        .seen            (seen_s),
        .first_err_valid (first_err_valid_s),
        .first_err_vec   (first_err_vec_s),
        .state_dbg       (state_dbg_s)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] v, input logic o);
        in_valid = 1'b1;
        in_vec   = v;
        in_out   = o;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_vec   = 2'b00;
        in_out   = 1'b0;
        #12;
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_err", {24'd0, err_count}, 32'd0);
        check("rst_seen", {28'd0, seen}, 32'd0);
        reset = 1'b0;
        idle_cycle();

        // Run 1: all correct NOR2 in order
        do_start();
        check("r1_busy", {31'd0, busy}, 32'd1);
        exp_q = '{8'd1, 8'd2, 8'd3, 8'd4};
        for (int i = 0; i < 4; i++) begin
            send(2'(i), (i == 0) ? 1'b1 : 1'b0);
            check("r1_scount", {24'd0, sample_count}, {24'd0, exp_q.pop_front()});
            if (i < 3) check("r1_done_early", {31'd0, done}, 32'd0);
        end
        check("r1_done", {31'd0, done}, 32'd1);
        check("r1_pass", {31'd0, pass}, 32'd1);
        check("r1_err", {24'd0, err_count}, 32'd0);
        check("r1_seen", {28'd0, seen}, 32'hf);
        check("r1_busy_end", {31'd0, busy}, 32'd0);
        idle_cycle();
        check("r1_done_pulse", {31'd0, done}, 32'd0);
        check("r1_pass_hold", {31'd0, pass}, 32'd1);

        // Run 2: vector 01 wrong
        do_start();
        check("r2_pass_clr", {31'd0, pass}, 32'd0);
        send(2'b00, 1'b1);
        send(2'b01, 1'b1);
        send(2'b10, 1'b0);
        send(2'b11, 1'b0);
        check("r2_done", {31'd0, done}, 32'd1);
        check("r2_pass", {31'd0, pass}, 32'd0);
        check("r2_err", {24'd0, err_count}, 32'd1);
        check("r2_fev", {31'd0, first_err_valid}, 32'd1);
        check("r2_fevec", {30'd0, first_err_vec}, 32'd1);

        // Run 3: out of order with a duplicate
        do_start();
        check("r3_fev_clr", {31'd0, first_err_valid}, 32'd0);
        send(2'b11, 1'b0);
        send(2'b00, 1'b1);
        send(2'b00, 1'b1);
        check("r3_dup_done", {31'd0, done}, 32'd0);
        check("r3_dup_seen", {28'd0, seen}, 32'h9);
        send(2'b10, 1'b0);
        check("r3_busy", {31'd0, busy}, 32'd1);
        send(2'b01, 1'b0);
        check("r3_done", {31'd0, done}, 32'd1);
        check("r3_scount", {24'd0, sample_count}, 32'd5);
        check("r3_pass", {31'd0, pass}, 32'd1);

        // Run 4: asynchronous reset mid-collect
        do_start();
        send(2'b00, 1'b1);
        send(2'b01, 1'b1);
        check("r4_pre_scount", {24'd0, sample_count}, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("r4_rst_ready", {31'd0, in_ready}, 32'd0);
        check("r4_rst_seen", {28'd0, seen}, 32'd0);
        check("r4_rst_scount", {24'd0, sample_count}, 32'd0);
        check("r4_rst_err", {24'd0, err_count}, 32'd0);
        check("r4_rst_fev", {31'd0, first_err_valid}, 32'd0);
        reset = 1'b0;
        idle_cycle();
        do_start();
        for (int i = 3; i >= 0; i--) send(2'(i), (i == 0) ? 1'b1 : 1'b0);
        check("r4_done", {31'd0, done}, 32'd1);
        check("r4_pass", {31'd0, pass}, 32'd1);
        check("r4_scount", {24'd0, sample_count}, 32'd4);

        // Run 5: saturation, six wrong 00 samples then the rest correct
        do_start();
        for (int i = 0; i < 6; i++) send(2'b00, 1'b0);
        send(2'b01, 1'b0);
        send(2'b10, 1'b0);
        send(2'b11, 1'b0);
        check("r5_done_s", {31'd0, done_s}, 32'd1);
        check("r5_err_s", {30'd0, err_count_s}, 32'd3);
        check("r5_scount_s", {30'd0, sample_count_s}, 32'd3);
        check("r5_pass_s", {31'd0, pass_s}, 32'd0);
        check("r5_err", {24'd0, err_count}, 32'd6);
        check("r5_scount", {24'd0, sample_count}, 32'd9);
        check("r5_pass", {31'd0, pass}, 32'd0);
        check("r5_fevec", {30'd0, first_err_vec}, 32'd0);

        // Run 6: start with in_valid in REPORT takes no sample
        start    = 1'b1;
        in_valid = 1'b1;
        in_vec   = 2'b10;
        in_out   = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        check("r6_scount", {24'd0, sample_count}, 32'd0);
        check("r6_err", {24'd0, err_count}, 32'd0);
        check("r6_seen", {28'd0, seen}, 32'd0);
        check("r6_busy", {31'd0, busy}, 32'd1);
        check("r6_ready", {31'd0, in_ready}, 32'd1);
        check("r6_pass", {31'd0, pass}, 32'd0);

        // start while collecting is ignored
        send(2'b10, 1'b1);
        do_start();
        check("r6_start_ign_sc", {24'd0, sample_count}, 32'd1);
        check("r6_start_ign_err", {24'd0, err_count}, 32'd1);
        check("r6_start_ign_fevec", {30'd0, first_err_vec}, 32'd2);
        check("r6_start_ign_busy", {31'd0, busy}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
